// File: rtl/hdmi_pix_fifo.sv
// Single-clock pixel FIFO for the HDMI output path: standard or first-word-fall-through
// read, programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags.
module hdmi_pix_fifo #(
  parameter int DATA_W  = 24,
  parameter int DEPTH_W = 8,
  parameter int FWFT    = 0,
  parameter int AF_NUM  = 255,
  parameter int AE_NUM  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                wr_full,
  output logic                almost_full,
  input  logic                rd_en,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_empty,
  output logic                almost_empty,
  output logic [DEPTH_W:0]    level,
  output logic                overflow,
  output logic                underflow,
  input  logic                err_clr
);

  localparam int DEPTH = 1 << DEPTH_W;
  localparam logic [DEPTH_W:0] AF_LVL = AF_NUM[DEPTH_W:0];
  localparam logic [DEPTH_W:0] AE_LVL = AE_NUM[DEPTH_W:0];

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DEPTH_W:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_W:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_W:0]   level_q, level_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               wr_acc, rd_acc;
  logic [DATA_W-1:0]  head;

  // Extra pointer bit distinguishes full from empty when the address bits match.
  assign rd_empty = (wr_ptr_q == rd_ptr_q);
  assign wr_full  = (wr_ptr_q[DEPTH_W] != rd_ptr_q[DEPTH_W]) &&
                    (wr_ptr_q[DEPTH_W-1:0] == rd_ptr_q[DEPTH_W-1:0]);

  assign almost_full  = (level_q >= AF_LVL);
  assign almost_empty = (level_q <= AE_LVL);
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  assign wr_acc = wr_en && !wr_full;
  assign rd_acc = rd_en && !rd_empty;
  assign head   = mem[rd_ptr_q[DEPTH_W-1:0]];

  assign rd_data = (FWFT != 0) ? head : rd_data_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    rd_data_d = rd_data_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      rd_data_d = head;
    end
    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    // A new error in the same cycle as err_clr must survive the clear.
    if (err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (wr_en && wr_full) ovf_d = 1'b1;
    // A read paired with a write into an empty FIFO loses nothing; only a lone read underflows.
    if (rd_en && rd_empty && !wr_en) unf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      rd_data_q <= rd_data_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  // Storage is never cleared; reset only makes old words unreachable.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem[wr_ptr_q[DEPTH_W-1:0]] <= wr_data;
  end

endmodule

// File: tb/tb_hdmi_pix_fifo.sv
// Bench for hdmi_pix_fifo: standard and FWFT instances share stimulus and are checked
// every cycle against a queue-based model, plus directed literal checks.
module tb_hdmi_pix_fifo;
  localparam int DW = 24;
  localparam int DWD = 4;
  localparam int DEPTH = 16;
  localparam int AFN = 12;
  localparam int AEN = 3;

  logic clk = 1'b0;
  logic rst, wr_en, rd_en, err_clr;
  logic [DW-1:0] wr_data;

  logic s_full, s_af, s_empty, s_ae, s_ovf, s_unf;
  logic [DW-1:0] s_rd;
  logic [DWD:0] s_lvl;
  logic f_full, f_af, f_empty, f_ae, f_ovf, f_unf;
  logic [DW-1:0] f_rd;
  logic [DWD:0] f_lvl;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  logic [DW-1:0] mq [$];
  logic [DW-1:0] m_rd;
  bit m_ovf, m_unf;

  always #5 clk = ~clk;

  hdmi_pix_fifo #(.DATA_W(DW), .DEPTH_W(DWD), .FWFT(0), .AF_NUM(AFN), .AE_NUM(AEN)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_full(s_full),
    .almost_full(s_af), .rd_en(rd_en), .rd_data(s_rd), .rd_empty(s_empty),
    .almost_empty(s_ae), .level(s_lvl), .overflow(s_ovf), .underflow(s_unf), .err_clr(err_clr));

  hdmi_pix_fifo #(.DATA_W(DW), .DEPTH_W(DWD), .FWFT(1), .AF_NUM(AFN), .AE_NUM(AEN)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_full(f_full),
    .almost_full(f_af), .rd_en(rd_en), .rd_data(f_rd), .rd_empty(f_empty),
    .almost_empty(f_ae), .level(f_lvl), .overflow(f_ovf), .underflow(f_unf), .err_clr(err_clr));

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: one clock edge applied to the queue.
  task automatic model_step();
    bit full, empty;
    if (rst) begin
      mq.delete();
      m_rd = '0;
      m_ovf = 0;
      m_unf = 0;
      return;
    end
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    if (err_clr) begin m_ovf = 0; m_unf = 0; end
    if (wr_en && full) m_ovf = 1;
    if (rd_en && empty && !wr_en) m_unf = 1;
    if (rd_en && !empty) m_rd = mq.pop_front();
    if (wr_en && !full) mq.push_back(wr_data);
  endtask

  task automatic cycle(input logic r, input logic we, input logic [DW-1:0] wd,
                       input logic re, input logic ec);
    rst = r; wr_en = we; wr_data = wd; rd_en = re; err_clr = ec;
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      int n;
      n = mq.size();
      chk("s_level", 64'(s_lvl), 64'(n));
      chk("s_empty", 64'(s_empty), 64'(n == 0));
      chk("s_full", 64'(s_full), 64'(n == DEPTH));
      chk("s_afull", 64'(s_af), 64'(n >= AFN));
      chk("s_aempty", 64'(s_ae), 64'(n <= AEN));
      chk("s_ovf", 64'(s_ovf), 64'(m_ovf));
      chk("s_unf", 64'(s_unf), 64'(m_unf));
      chk("s_rd_data", 64'(s_rd), 64'(m_rd));
      chk("f_level", 64'(f_lvl), 64'(n));
      chk("f_empty", 64'(f_empty), 64'(n == 0));
      chk("f_full", 64'(f_full), 64'(n == DEPTH));
      chk("f_flags", 64'({f_af, f_ae, f_ovf, f_unf}),
          64'({n >= AFN, n <= AEN, m_ovf, m_unf}));
      if (n > 0) chk("f_rd_data", 64'(f_rd), 64'(mq[0]));
    end
  end

  initial begin
    rst = 1; wr_en = 0; rd_en = 0; err_clr = 0; wr_data = '0;
    m_rd = '0; m_ovf = 0; m_unf = 0;

    // Reset state
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk_en = 1;
    chk("rst_level", 64'(s_lvl), 0);
    chk("rst_flags", 64'({s_empty, s_ae, s_full, s_af, s_ovf, s_unf}), 64'b110000);
    chk("rst_rd_data", 64'(s_rd), 0);

    // Fill to full, then overflow
    for (int i = 0; i < 16; i++) cycle(0, 1, DW'(i), 0, 0);
    chk("fill_level", 64'(s_lvl), 16);
    chk("fill_full", 64'(s_full), 1);
    cycle(0, 1, 24'h99, 0, 0);
    chk("ovf_set", 64'(s_ovf), 1);
    chk("ovf_level", 64'(s_lvl), 16);

    // Full with both requests: read wins, write dropped
    cycle(0, 1, 24'h77, 1, 0);
    chk("full_rw_level", 64'(s_lvl), 15);
    chk("full_rw_data", 64'(s_rd), 0);
    for (int i = 1; i < 16; i++) begin
      cycle(0, 0, 0, 1, 0);
      chk("drain_data", 64'(s_rd), 64'(i));
    end
    chk("drain_empty", 64'(s_empty), 1);
    cycle(0, 0, 0, 0, 1);
    chk("ovf_clr", 64'(s_ovf), 0);

    // Empty with both requests: write wins, no underflow
    chk("empty_before", 64'(s_empty), 1);
    cycle(0, 1, 24'h5, 1, 0);
    chk("empty_rw_level", 64'(s_lvl), 1);
    chk("empty_rw_unf", 64'(s_unf), 0);

    // FWFT head word without rd_en
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 24'hABCDEF, 0, 0);
    chk("fwft_empty", 64'(f_empty), 0);
    chk("fwft_data", 64'(f_rd), 64'h0ABCDEF);
    cycle(0, 0, 0, 1, 0);
    chk("fwft_pop_empty", 64'(f_empty), 1);

    // Threshold transitions on fill and drain
    cycle(1, 0, 0, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      cycle(0, 1, DW'(i + 32'h100), 0, 0);
      if (i == 3)  chk("ae_at3", 64'(s_ae), 1);
      if (i == 4)  chk("ae_at4", 64'(s_ae), 0);
      if (i == 11) chk("af_at11", 64'(s_af), 0);
      if (i == 12) chk("af_at12", 64'(s_af), 1);
    end
    for (int i = 15; i >= 0; i--) begin
      cycle(0, 0, 0, 1, 0);
      if (i == 12) chk("af_dn12", 64'(s_af), 1);
      if (i == 11) chk("af_dn11", 64'(s_af), 0);
      if (i == 4)  chk("ae_dn4", 64'(s_ae), 0);
      if (i == 3)  chk("ae_dn3", 64'(s_ae), 1);
    end

    // Streaming at level 5 across pointer wrap
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, DW'(i + 32'h200), 0, 0);
    for (int i = 0; i < 100; i++) cycle(0, 1, DW'(i + 32'h205), 1, 0);
    chk("stream_level", 64'(s_lvl), 5);
    chk("stream_data", 64'(s_rd), 64'h263);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    chk("unf_set", 64'(s_unf), 1);
    cycle(0, 0, 0, 0, 1);
    chk("unf_clr", 64'(s_unf), 0);

    // Randomised traffic with varying bias
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 200; i++) begin
        logic r, we, re, ec;
        int wp;
        wp = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
        r  = ($urandom_range(0, 199) == 0);
        we = ($urandom_range(0, 99) < wp);
        re = ($urandom_range(0, 99) < (ph == 3 ? 50 : 100 - wp));
        ec = ($urandom_range(0, 29) == 0);
        cycle(r, we, DW'($urandom), re, ec);
      end
    end

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
